// File: rtl/cmd_arbiter_queue_pkg.sv
// Shared command encoding and channel bundling types for the game-FSM command front-end.
package cmd_arbiter_queue_pkg;

   typedef enum logic [2:0] {
      NONE   = 3'd0,
      LEFT   = 3'd1,
      RIGHT  = 3'd2,
      ROTATE = 3'd3,
      DOWN   = 3'd4,
      DROP   = 3'd5,
      HOLD   = 3'd6,
      PAUSE  = 3'd7
   } state_type;

   localparam int CMD_NCH   = 4;
   localparam int CMD_QSIZE = 8;
   localparam int CMD_W     = $bits(state_type);

   typedef struct packed {
      logic      valid;
      state_type cmd;
   } cmd_req_t;

   function automatic logic cmd_is_live(input state_type c);
      return c != NONE;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with flush, occupancy count and a tail peek used for coalescing.
module cmd_fifo #(
   parameter int  DEPTH = 8,
   parameter type T     = logic [7:0]
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  T                       wr_data,
   output T                       head,
   output T                       tail,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);

   T               mem_r [DEPTH];
   logic [AW-1:0]  wr_ptr_r;
   logic [AW-1:0]  rd_ptr_r;
   logic [AW:0]    level_r;
   logic [AW-1:0]  tail_ptr_s;
   logic           do_push_s;
   logic           do_pop_s;
   logic           full_s;

   assign full_s     = (level_r == (AW+1)'(DEPTH));
   assign do_pop_s   = pop && (level_r != {(AW+1){1'b0}});
   // When full, a push only fits because the head leaves in the same cycle.
   assign do_push_s  = push && (!full_s || do_pop_s);
   assign tail_ptr_s = wr_ptr_r - 1'b1;

   assign head  = mem_r[rd_ptr_r];
   assign tail  = mem_r[tail_ptr_s];
   assign level = level_r;

   // Storage, pointers and occupancy; pointers wrap modulo DEPTH.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= T'(0);
         end
      end else if (flush) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
            wr_ptr_r        <= wr_ptr_r + 1'b1;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   level_r <= level_r + 1'b1;
            2'b01:   level_r <= level_r - 1'b1;
            default: level_r <= level_r;
         endcase
      end
   end

endmodule

// File: rtl/cmd_arbiter_queue.sv
// Command front-end: per-channel pending latches, fixed-priority arbiter (channel 0 first),
// optional tail coalescing and a FIFO drained by the game FSM, with overflow accounting.
module cmd_arbiter_queue
   import cmd_arbiter_queue_pkg::*;
#(
   parameter int                      NCH           = CMD_NCH,
   parameter int                      DEPTH         = CMD_QSIZE,
   parameter logic [2**CMD_W-1:0]     COALESCE_MASK = {(2**CMD_W){1'b0}},
   parameter int                      DROP_W        = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NCH-1:0]             req_valid,
   input  state_type [NCH-1:0]        req_cmd,
   input  logic                       flush,
   input  logic                       pop,
   output state_type                  cmd,
   output logic                       cmd_valid,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic [DROP_W-1:0]          drop_cnt
);
   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int LW = $clog2(DEPTH) + 1;

   logic [NCH-1:0]     pend_valid_r;
   state_type          pend_cmd_r [NCH];
   logic [NCH-1:0]     eff_valid_s;
   state_type          eff_cmd_s [NCH];
   logic [IW-1:0]      sel_idx_s;
   logic               sel_found_s;
   state_type          sel_cmd_s;
   logic               coal_s;
   logic               full_s;
   logic               drop_s;
   logic               push_s;
   logic               overflow_r;
   logic [DROP_W-1:0]  drop_cnt_r;
   state_type          head_s;
   state_type          tail_s;
   logic [LW-1:0]      level_s;

   // Fresh requests override the latched command so the latest one on a channel wins.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         if (req_valid[i] && cmd_is_live(req_cmd[i])) begin
            eff_valid_s[i] = 1'b1;
            eff_cmd_s[i]   = req_cmd[i];
         end else begin
            eff_valid_s[i] = pend_valid_r[i];
            eff_cmd_s[i]   = pend_cmd_r[i];
         end
      end
   end

   // Lowest-index live channel wins; scanning downwards leaves the smallest index.
   always_comb begin
      sel_idx_s = {IW{1'b0}};
      for (int i = NCH - 1; i >= 0; i--) begin
         sel_idx_s = eff_valid_s[i] ? IW'(i) : sel_idx_s;
      end
   end

   assign sel_found_s = |eff_valid_s;
   assign sel_cmd_s   = eff_cmd_s[sel_idx_s];
   assign full_s      = (level_s == LW'(DEPTH));
   assign coal_s      = COALESCE_MASK[sel_cmd_s] && (level_s != {LW{1'b0}}) && (tail_s == sel_cmd_s);
   assign drop_s      = sel_found_s && !flush && !coal_s && full_s && !pop;
   assign push_s      = sel_found_s && !flush && !coal_s && !(full_s && !pop);

   // Pending latches: the winner is consumed, everyone else keeps waiting.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_valid_r <= {NCH{1'b0}};
         for (int i = 0; i < NCH; i++) begin
            pend_cmd_r[i] <= NONE;
         end
      end else if (flush) begin
         pend_valid_r <= {NCH{1'b0}};
         for (int i = 0; i < NCH; i++) begin
            pend_cmd_r[i] <= NONE;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            pend_valid_r[i] <= eff_valid_s[i] && !(sel_found_s && (sel_idx_s == IW'(i)));
            pend_cmd_r[i]   <= eff_cmd_s[i];
         end
      end
   end

   // Overflow accounting survives flush; only reset clears it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_r <= 1'b0;
         drop_cnt_r <= {DROP_W{1'b0}};
      end else if (drop_s) begin
         overflow_r <= 1'b1;
         drop_cnt_r <= (&drop_cnt_r) ? drop_cnt_r : drop_cnt_r + 1'b1;
      end else begin
         overflow_r <= overflow_r;
         drop_cnt_r <= drop_cnt_r;
      end
   end

   cmd_fifo #(
      .DEPTH (DEPTH),
      .T     (state_type)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .push    (push_s),
      .pop     (pop),
      .wr_data (sel_cmd_s),
      .head    (head_s),
      .tail    (tail_s),
      .level   (level_s)
   );

   assign cmd_valid = (level_s != {LW{1'b0}});
   assign cmd       = cmd_valid ? head_s : NONE;
   assign level     = level_s;
   assign overflow  = overflow_r;
   assign drop_cnt  = drop_cnt_r;

endmodule
